// File: rtl/training_interval_scheduler.sv
// Workout interval sequencer: alternates WORK/REST countdowns for ROUNDS rounds,
// paced by a resynchronised 1 Hz tick, with a short buzzer burst at each phase entry.
module training_interval_scheduler #(
  parameter int WORK_SEC = 30,
  parameter int REST_SEC = 10,
  parameter int ROUNDS   = 4,
  parameter int BEEP_SEC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pause,
  input  logic       abort,
  input  logic       sec_clk,
  input  logic       tone_clk,
  output logic [1:0] phase,
  output logic [3:0] round_num,
  output logic [7:0] sec_left,
  output logic       done,
  output logic       buzzer
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WORK = 2'b01,
    REST = 2'b10,
    DONE = 2'b11
  } phase_e;

  localparam logic [7:0] WORK_LD = 8'(WORK_SEC);
  localparam logic [7:0] REST_LD = 8'(REST_SEC);
  localparam logic [7:0] BEEP_LD = 8'(BEEP_SEC);
  localparam logic [3:0] LAST_RD = 4'(ROUNDS);

  logic [2:0] sync_q;
  logic       tick, adv;

  phase_e     phase_q, phase_d;
  logic [3:0] round_q, round_d;
  logic [7:0] sec_q, sec_d;
  logic       done_q, done_d;
  logic       beep_en_q, beep_en_d;
  logic [7:0] beep_cnt_q, beep_cnt_d;

  // Two flops of metastability margin, third for rising-edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 3'b000;
    else        sync_q <= {sync_q[1:0], sec_clk};
  end

  assign tick = sync_q[1] & ~sync_q[2];
  assign adv  = tick & ~pause;

  always_comb begin
    phase_d    = phase_q;
    round_d    = round_q;
    sec_d      = sec_q;
    done_d     = done_q;
    beep_en_d  = beep_en_q;
    beep_cnt_d = beep_cnt_q;
    if (abort) begin
      phase_d    = IDLE;
      round_d    = 4'd0;
      sec_d      = 8'd0;
      done_d     = 1'b0;
      beep_en_d  = 1'b0;
      beep_cnt_d = 8'd0;
    end else if (start && (phase_q == IDLE || phase_q == DONE)) begin
      phase_d    = WORK;
      round_d    = 4'd1;
      sec_d      = WORK_LD;
      done_d     = 1'b0;
      beep_en_d  = 1'b1;
      beep_cnt_d = BEEP_LD;
    end else if (adv) begin
      if (beep_en_q) begin
        if (beep_cnt_q <= 8'd1) begin
          beep_en_d  = 1'b0;
          beep_cnt_d = 8'd0;
        end else begin
          beep_cnt_d = beep_cnt_q - 8'd1;
        end
      end
      if (phase_q == WORK || phase_q == REST) begin
        if (sec_q > 8'd1) begin
          sec_d = sec_q - 8'd1;
        end else begin
          // Expiry: phase entry reloads the beep, overriding the decrement above.
          beep_en_d  = 1'b1;
          beep_cnt_d = BEEP_LD;
          if (phase_q == REST) begin
            phase_d = WORK;
            round_d = round_q + 4'd1;
            sec_d   = WORK_LD;
          end else if (round_q < LAST_RD) begin
            phase_d = REST;
            sec_d   = REST_LD;
          end else begin
            phase_d = DONE;
            sec_d   = 8'd0;
            done_d  = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= IDLE;
      round_q    <= 4'd0;
      sec_q      <= 8'd0;
      done_q     <= 1'b0;
      beep_en_q  <= 1'b0;
      beep_cnt_q <= 8'd0;
    end else begin
      phase_q    <= phase_d;
      round_q    <= round_d;
      sec_q      <= sec_d;
      done_q     <= done_d;
      beep_en_q  <= beep_en_d;
      beep_cnt_q <= beep_cnt_d;
    end
  end

  assign phase     = phase_q;
  assign round_num = round_q;
  assign sec_left  = sec_q;
  assign done      = done_q;
  assign buzzer    = tone_clk & beep_en_q & ~pause;

endmodule
